multiplicador_seq: RTL and testbench



---
 rtl/multiplicador_seq.sv | 115 +++++++++++
 tb/tb_multiplicador_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/multiplicador_seq.sv
// Sequential unsigned shift-and-add multiplier.
// It computes a WIDTH x WIDTH -> 2*WIDTH product with one partial-product step per clock.
// The handshake is start/busy/done. An accept edge is followed by WIDTH RUN edges and then one DONE cycle.
module multiplicador_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_step;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;
  logic               last_iter;

  // One iteration: add m into the accumulator when the multiplier LSB is set, then shift right.
  // The carry lands in the MSB, so the shifted value never overflows.
  always_comb begin
    if (p[0]) begin
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};
    end else begin
      sum = {1'b0, p[2*WIDTH-1:WIDTH]};
    end
    p_step    = {sum, p[WIDTH-1:1]};
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. busy and done depend only on the registered state.
  // NOTE: defaults are assigned first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operands are captured on the accept edge and iterated in RUN.
  // The product register is loaded only on the final iteration.
  // NOTE: every datapath register is reset, so an aborted run leaves no residue in m, p or product.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      m       <= '0;
      p       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= mcand;
            p   <= {{WIDTH{1'b0}}, mplier};
            cnt <= '0;
          end
        end
        RUN: begin
          p   <= p_step;
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            product <= p_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench for multiplicador_seq at WIDTH=32.
// The reference model is plain 64-bit a*b together with the documented cycle timing.
module tb_multiplicador_seq;

  localparam int W = 32;

  logic           clk;
  logic           r;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_errors = 0;

  // Last result the model expects the product register to hold.
  logic [2*W-1:0] prev_product;

  multiplicador_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .r       (r),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one multiplication from an IDLE cycle and checks the cycle timing and the result.
  // When noisy is set, start stays high throughout and the operands change every RUN cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy,
                        input string tag, output logic [2*W-1:0] got);
    logic [2*W-1:0] exp;
    bit             ok;
    exp = 64'(a) * 64'(b);
    @(negedge clk);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(posedge clk); #1;
    ok = (busy === 1'b1) && (done === 1'b0);
    if (!noisy) start = 1'b0;
    for (int j = 1; j < W; j++) begin
      if (noisy) begin
        @(negedge clk);
        mcand  = $urandom;
        mplier = $urandom;
      end
      @(posedge clk); #1;
      ok = ok && (busy === 1'b1) && (done === 1'b0) && (product === prev_product);
    end
    check({tag, "_run"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
    check({tag, "_done"}, {62'd0, busy, done}, 64'd1);
    check({tag, "_product"}, product, exp);
    got          = product;
    prev_product = exp;
    @(posedge clk); #1;
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    check({tag, "_hold"}, product, exp);
    if (noisy) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  logic [2*W-1:0] res;
  logic [W-1:0]   ra;
  logic [W-1:0]   rb;

  initial begin
    r            = 1'b0;
    start        = 1'b0;
    mcand        = '0;
    mplier       = '0;
    prev_product = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, product}, 66'd0);
    @(negedge clk);
    r = 1'b1;

    run_op(32'd31, 32'd108, 1'b0, "basic", res);
    check("basic_const", res, 64'd3348);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max", res);
    check("max_const", res, 64'hFFFF_FFFE_0000_0001);

    run_op(32'd0, 32'hDEAD_BEEF, 1'b0, "zero", res);
    check("zero_const", res, 64'd0);
    run_op(32'd1, 32'hDEAD_BEEF, 1'b0, "ident", res);
    check("ident_const", res, 64'h0000_0000_DEAD_BEEF);

    run_op(32'd1234, 32'd5678, 1'b1, "noisy", res);
    check("noisy_const", res, 64'd7006652);

    // Back-to-back: the second accept lands on the first IDLE edge after DONE.
    run_op(32'd1000, 32'd3, 1'b0, "b2b_a", res);
    run_op(32'd77, 32'd99, 1'b0, "b2b_b", res);

    // Reset mid-operation: pull r low between edges during iteration 10.
    @(negedge clk);
    start  = 1'b1;
    mcand  = 32'h1234_5678;
    mplier = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    r = 1'b0;
    #1;
    check("abort_outputs", {busy, done, product}, 66'd0);
    prev_product = '0;
    @(negedge clk);
    r = 1'b1;
    run_op(32'd7, 32'd6, 1'b0, "after_abort", res);
    check("after_abort_const", res, 64'd42);

    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 8)
        0: ra = '0;
        1: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ra, rb, ($urandom_range(0, 3) == 0), "rand", res);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
